// File: rtl/touch_event_encoder.sv
// Debounces the MPR121 electrode bitmap on periodic sample ticks and queues {key, press} edge events in a small FIFO.
// Optional build macro TOUCH_EVENT_TIMESTAMP_EN adds a 16-bit tick timestamp to every queued event.
//
// state    | meaning
// ST_IDLE  | no key has an unreported edge
// ST_SCAN  | edges pending and FIFO has room: push the lowest pending key this cycle
// ST_STALL | edges pending but FIFO full: hold pending bits until the consumer pops
module touch_event_encoder #(
    parameter int NUM_KEYS         = 12,
    parameter int TICK_CYCLES      = 100000,
    parameter int DEBOUNCE_SAMPLES = 3,
    parameter int FIFO_DEPTH       = 8
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    input  logic [NUM_KEYS-1:0]         touch_status_in,
    input  logic                        touch_valid_in,
    output logic                        event_valid_out,
    input  logic                        event_ready_in,
    output logic [3:0]                  event_key_out,
    output logic                        event_press_out,
    output logic [NUM_KEYS-1:0]         stable_keys_out,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count_out
`ifdef TOUCH_EVENT_TIMESTAMP_EN
    ,
    output logic [15:0]                 event_time_out
`endif
);

    localparam int TW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
`ifdef TOUCH_EVENT_TIMESTAMP_EN
    localparam int EW = 5 + 16;
`else
    localparam int EW = 5;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_STALL} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [TW-1:0]       r_tick_cnt;
    logic                w_tick;
    logic [NUM_KEYS-1:0] r_stable;
    logic [NUM_KEYS-1:0] r_pending;
    logic [NUM_KEYS-1:0] w_toggle;
    logic [NUM_KEYS-1:0] w_clr;
    logic [NUM_KEYS-1:0] w_pend_nxt;
    logic [2:0]          r_deb_cnt     [NUM_KEYS];
    logic [2:0]          w_deb_cnt_nxt [NUM_KEYS];
    logic [3:0]          w_sel;
    logic                w_sel_press;
    logic [EW-1:0]       r_mem [FIFO_DEPTH];
    logic [EW-1:0]       w_push_data;
    logic [EW-1:0]       w_head;
    logic [PW-1:0]       r_wr_ptr;
    logic [PW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;
    logic [CW-1:0]       w_count_nxt;
    logic                w_push;
    logic                w_pop;
    logic                w_valid;

    // Prescaler freezes while the controller's bitmap is not valid.
    assign w_tick = touch_valid_in && (r_tick_cnt == TW'(TICK_CYCLES - 1));

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_tick_cnt <= '0;
        end else if (touch_valid_in) begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
        end
    end

    always_comb begin
        w_toggle = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            w_deb_cnt_nxt[k] = r_deb_cnt[k];
            if (w_tick) begin
                if (touch_status_in[k] != r_stable[k]) begin
                    if (r_deb_cnt[k] == 3'(DEBOUNCE_SAMPLES - 1)) begin
                        w_toggle[k]      = 1'b1;
                        w_deb_cnt_nxt[k] = '0;
                    end else begin
                        w_deb_cnt_nxt[k] = r_deb_cnt[k] + 3'd1;
                    end
                end else begin
                    w_deb_cnt_nxt[k] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_stable <= '0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                r_deb_cnt[k] <= '0;
            end
        end else begin
            r_stable <= r_stable ^ w_toggle;
            for (int k = 0; k < NUM_KEYS; k++) begin
                r_deb_cnt[k] <= w_deb_cnt_nxt[k];
            end
        end
    end

    always_comb begin
        w_sel       = '0;
        w_sel_press = 1'b0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (r_pending[k]) begin
                w_sel       = 4'(k);
                w_sel_press = r_stable[k];
            end
        end
    end

    // Clear before toggle: a fresh flip on the bit being scanned leaves it set.
    assign w_clr      = w_push ? (NUM_KEYS'(1) << w_sel) : '0;
    assign w_pend_nxt = (r_pending & ~w_clr) ^ w_toggle;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pend_nxt;
        end
    end

    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && event_ready_in;
    assign w_push  = (r_state == ST_SCAN);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // State mirrors next-cycle pending/full flags so SCAN pushes without extra latency.
    always_comb begin
        w_state_nxt = ST_IDLE;
        if (w_pend_nxt != '0) begin
            w_state_nxt = (w_count_nxt == CW'(FIFO_DEPTH)) ? ST_STALL : ST_SCAN;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

`ifdef TOUCH_EVENT_TIMESTAMP_EN
    logic [15:0] r_time;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_time <= '0;
        end else if (w_tick) begin
            r_time <= r_time + 16'd1;
        end
    end

    assign w_push_data    = {r_time, w_sel, w_sel_press};
    assign event_time_out = w_valid ? w_head[20:5] : '0;
`else
    assign w_push_data = {w_sel, w_sel_press};
`endif

    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    assign w_head          = r_mem[r_rd_ptr];
    assign event_valid_out = w_valid;
    assign event_key_out   = w_valid ? w_head[4:1] : '0;
    assign event_press_out = w_valid ? w_head[0] : 1'b0;
    assign stable_keys_out = r_stable;
    assign fifo_count_out  = r_count;

endmodule
